// File: rtl/prng_feed.sv
// ---------------------------------------------------------------------------
// prng_feed
//
// Purpose:
//   xorshift128 random-number generator feeding a 2-entry word FIFO. Each
//   enabled, unstalled cycle performs one generator step; four consecutive
//   32-bit step outputs are packed into one 128-bit word (step k lands in
//   bits [32k+31:32k]). The packed word is pushed on the edge of step 3.
//   The consumer sees the FIFO head on rng/rng_valid and pops it with
//   rng_extract.
//
// Ports:
//   clk          in   1    sole clock, rising edge
//   rst_n        in   1    asynchronous active-low reset
//   ena          in   1    generator step enable
//   seed_valid   in   1    one-cycle strobe: load seed, flush FIFO and partial
//   seed         in   128  {x,y,z,w}, MSB-first, 32 bits each
//   rng_extract  in   1    consumer pops the current word
//   rng_valid    out  1    rng holds an unconsumed word
//   rng          out  128  FIFO head (128'h0 when empty)
//   words_served out  32   popped-word counter (only with PRNG_FEED_CNT_EN)
//
// Optional feature:
//   Define PRNG_FEED_CNT_EN to add the words_served port and its counter.
//   The counter is cleared by reset only; a seed load leaves it untouched.
// ---------------------------------------------------------------------------
module prng_feed (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         seed_valid,
  input  logic [127:0] seed,
  input  logic         rng_extract,
  output logic         rng_valid,
  output logic [127:0] rng
`ifdef PRNG_FEED_CNT_EN
  ,
  output logic [31:0]  words_served
`endif
);

  // Marsaglia's reference starting state; also substituted for an all-zero
  // seed, which would lock xorshift at zero forever.
  localparam logic [31:0] X_INIT = 32'd123456789;
  localparam logic [31:0] Y_INIT = 32'd362436069;
  localparam logic [31:0] Z_INIT = 32'd521288629;
  localparam logic [31:0] W_INIT = 32'd88675123;

  // -------------------------------------------------------------------------
  // Generator state
  // -------------------------------------------------------------------------
  logic [31:0] x_q, y_q, z_q, w_q;
  logic [31:0] x_d, y_d, z_d, w_d;
  logic [1:0]  step_cnt_q, step_cnt_d;

  // FIFO bookkeeping
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;

  // Control decodes
  logic        step_en;
  logic        push;
  logic        pop;
  logic [31:0] t_val;
  logic [31:0] new_w;
  logic [31:0] seed_x, seed_y, seed_z, seed_w;

  // Partial word (steps 0..2) and FIFO storage, flattened for muxing
  logic [95:0]  partial_flat;
  logic [127:0] assembled;
  logic [255:0] fifo_flat;

  always_comb begin
    t_val = x_q ^ (x_q << 11);
    new_w = w_q ^ (w_q >> 19) ^ t_val ^ (t_val >> 8);
  end

  // seed_valid wins over everything else in its cycle. Stepping stalls at
  // count==2 regardless of a pop in the same cycle, so a push never lands on
  // a full FIFO.
  always_comb begin
    step_en = ena && (count_q != 2'd2) && !seed_valid;
    push    = step_en && (step_cnt_q == 2'd3);
    pop     = rng_extract && (count_q != 2'd0) && !seed_valid;
  end

  // The word completes with the current step's output in the top lane.
  assign assembled = {new_w, partial_flat};

  always_comb begin
    if (seed == 128'h0) begin
      seed_x = X_INIT;
      seed_y = Y_INIT;
      seed_z = Z_INIT;
      seed_w = W_INIT;
    end else begin
      seed_x = seed[127:96];
      seed_y = seed[95:64];
      seed_z = seed[63:32];
      seed_w = seed[31:0];
    end
  end

  // -------------------------------------------------------------------------
  // Next-state for generator, step counter and FIFO pointers
  // -------------------------------------------------------------------------
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    w_d        = w_q;
    step_cnt_d = step_cnt_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (seed_valid) begin
      x_d        = seed_x;
      y_d        = seed_y;
      z_d        = seed_z;
      w_d        = seed_w;
      step_cnt_d = 2'd0;
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
    end else begin
      if (step_en) begin
        x_d        = y_q;
        y_d        = z_q;
        z_d        = w_q;
        w_d        = new_w;
        step_cnt_d = step_cnt_q + 2'd1;  // wraps 3 -> 0
      end
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= X_INIT;
      y_q        <= Y_INIT;
      z_q        <= Z_INIT;
      w_q        <= W_INIT;
      step_cnt_q <= 2'd0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      w_q        <= w_d;
      step_cnt_q <= step_cnt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Partial-word lanes: lane k captures the output of step k (k = 0..2).
  // Step 3 is never stored here; it goes straight into the FIFO entry.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [31:0] lane_q;
      logic [31:0] lane_d;

      always_comb begin
        lane_d = lane_q;
        if (seed_valid) begin
          lane_d = 32'h0;
        end else if (step_en && (step_cnt_q == 2'(gi))) begin
          lane_d = new_w;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_q <= 32'h0;
        end else begin
          lane_q <= lane_d;
        end
      end

      assign partial_flat[32*gi +: 32] = lane_q;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // FIFO entries: entry gi is written when the write pointer selects it.
  // Entries are cleared on seed so stale words never linger in storage.
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [127:0] ent_q;
      logic [127:0] ent_d;

      always_comb begin
        ent_d = ent_q;
        if (seed_valid) begin
          ent_d = 128'h0;
        end else if (push && (wr_ptr_q == 1'(gi))) begin
          ent_d = assembled;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ent_q <= 128'h0;
        end else begin
          ent_q <= ent_d;
        end
      end

      assign fifo_flat[128*gi +: 128] = ent_q;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Consumer-facing outputs
  // -------------------------------------------------------------------------
  always_comb begin
    rng_valid = (count_q != 2'd0);
    rng       = 128'h0;
    if (rng_valid) begin
      rng = rd_ptr_q ? fifo_flat[255:128] : fifo_flat[127:0];
    end
  end

`ifdef PRNG_FEED_CNT_EN
  logic [31:0] served_q, served_d;

  // Wraps naturally at 32 bits; only reset clears it.
  always_comb begin
    served_d = served_q;
    if (pop) begin
      served_d = served_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served_q <= 32'h0;
    end else begin
      served_q <= served_d;
    end
  end

  assign words_served = served_q;
`endif

endmodule

// File: doc/prng_feed.md
PRNG_FEED -- requirements
Module: prng_feed

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: ena  input  1  generator step enable.
REQ-004 SHALL have ports: seed_valid  input  1  one-cycle strobe to load seed.
REQ-005 SHALL have ports: seed  input  128  seed value, {x,y,z,w} MSB-first, 32 bits each.
REQ-006 SHALL have ports: rng_extract  input  1  consumer pops current word.
REQ-007 SHALL have ports: rng_valid  output  1  rng holds an unconsumed word.
REQ-008 SHALL have ports: rng  output  128  current random word (FIFO head).
REQ-009 SHALL have ports, only with PRNG_FEED_CNT_EN: words_served  output  32  count of popped words.

Function
REQ-010 SHALL implement xorshift128 on 32-bit state x,y,z,w: t=x^(x<<11); x<=y; y<=z; z<=w; w<=w^(w>>19)^t^(t>>8); step output = new w.
REQ-011 SHALL perform one step per cycle when ena=1 and FIFO count<2; otherwise state, step counter and partial word hold.
REQ-012 SHALL assemble 4 consecutive step outputs into one word, step k (k=0..3) into bits [32k+31:32k].
REQ-013 SHALL push the assembled word into a 2-entry FIFO on the edge of step 3; 2-bit step counter wraps 3->0.
REQ-014 SHALL stall stepping whenever count==2, even if a pop occurs that cycle (no push-while-full).
REQ-015 SHALL drive rng_valid=1 iff count>0, and rng = FIFO head when valid, 128'h0 when empty.
REQ-016 SHALL pop the head on a rising edge where rng_extract=1 and rng_valid=1; rng_extract while rng_valid=0 SHALL be ignored.
REQ-017 SHALL hold rng stable while rng_valid=1 and no pop occurs.
REQ-018 SHALL allow push and pop in the same cycle (count unchanged, new head = next entry).
REQ-019 SHALL, on seed_valid=1: load x,y,z,w from seed; flush FIFO and partial word; clear step counter; rng_valid=0 next cycle.
REQ-020 SHALL, for seed==128'h0, load the reset constants instead (all-zero state forbidden).
REQ-021 SHALL give seed_valid priority over rng_extract and stepping in the same cycle (no pop, no step, words_served unchanged).
REQ-022 SHALL produce the first word 4 enabled, unstalled cycles after reset/seed; rng_valid rises after the 4th step edge.

Reset
REQ-023 SHALL on rst_n=0, asynchronously: x=32'd123456789, y=32'd362436069, z=32'd521288629, w=32'd88675123.
REQ-024 SHALL on reset clear FIFO, count, step counter, partial word; rng_valid=0, rng=0, words_served=0.
REQ-025 SHALL resume operation on the first rising edge after rst_n deasserts; mid-operation reset discards all buffered words.

Configuration
REQ-026 SHALL, with PRNG_FEED_CNT_EN defined, include words_served: +1 per pop, wraps 32'hFFFFFFFF->0, not cleared by seed.
REQ-027 SHALL, without PRNG_FEED_CNT_EN, omit the words_served port and counter; all other behaviour identical.

Verification
REQ-028 Reset release, ena=1, no extract -> rng_valid rises after 4th edge; rng[31:0]=32'hDCA345EA; second word ready 4 cycles later, then stepping stalls at count=2.
REQ-029 FIFO full, pulse rng_extract 1 cycle -> head advances to word 2, count=1, stepping resumes next cycle, next word after 4 steps.
REQ-030 rng_extract held high continuously, ena=1 -> one pop per produced word, rng_valid pulses 1 cycle per 4 cycles, no word lost or duplicated vs. reference model.
REQ-031 seed_valid with seed=0 while count=2 and rng_extract=1 -> rng_valid=0 next cycle, no pop, first word after 4 steps equals reset-constant first word 32'hDCA345EA in [31:0].
REQ-032 ena toggled 0 mid-word (after 2 steps) for 5 cycles -> partial word held; word completes 2 enabled cycles after ena returns, matches uninterrupted model.
REQ-033 PRNG_FEED_CNT_EN defined, 3 pops then seed load then 2 pops -> words_served=5; rst_n pulse -> 0.
